// File: rtl/frame_serializer_if.sv
// Word handshake and serial-line signals of frame_serializer.
// master drives words in; slave is the serializer.
interface frame_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             tx_bit;
  logic             tx_frame;
  logic             done;
  logic [31:0]      frame_cnt;

  modport master (
    output in_valid, in_data,
    input  in_ready, tx_bit, tx_frame, done, frame_cnt
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, tx_bit, tx_frame, done, frame_cnt
  );
endinterface

// File: rtl/frame_serializer.sv
// Parallel-to-serial framer: start bit, WIDTH data bits LSB first,
// even-parity bit, stop bit, with a wrapping count of completed frames.
module frame_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  frame_serializer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             parity;
  logic [5:0]       bit_idx;
  logic             line;
  logic             in_frame;
  logic             stop_pulse;
  logic [31:0]      count;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.tx_bit    = line;
  assign bus.tx_frame  = in_frame;
  assign bus.done      = stop_pulse;
  assign bus.frame_cnt = count;

  // Outputs are registered one state ahead: each branch loads the value
  // the line must carry in the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      parity     <= 1'b0;
      bit_idx    <= '0;
      line       <= 1'b1;
      in_frame   <= 1'b0;
      stop_pulse <= 1'b0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            state    <= START;
            shreg    <= bus.in_data;
            parity   <= ^bus.in_data;
            bit_idx  <= '0;
            line     <= 1'b0;
            in_frame <= 1'b1;
          end
        end
        START: begin
          state   <= DATA;
          line    <= shreg[0];
          shreg   <= shreg >> 1;
          bit_idx <= '0;
        end
        DATA: begin
          if (bit_idx == 6'(WIDTH - 1)) begin
            state <= PARITY;
            line  <= parity;
          end else begin
            line    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 6'd1;
          end
        end
        PARITY: begin
          state      <= STOP;
          line       <= 1'b1;
          stop_pulse <= 1'b1;
        end
        STOP: begin
          state      <= IDLE;
          stop_pulse <= 1'b0;
          in_frame   <= 1'b0;
          count      <= count + 32'd1;
        end
        default: begin
          state    <= IDLE;
          line     <= 1'b1;
          in_frame <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: reset, framed words, stuck valid,
// mid-frame reset, WIDTH=1 and counter wrap.
module tb_frame_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_cnt = '0;
  logic [31:0] base_cnt;
  int          pos;
  logic [7:0]  word;
  logic [7:0]  d;
  logic        exp_bit;
  logic [0:3]  seq1;

  always #5 clk = ~clk;

  frame_serializer_if #(.WIDTH(8)) bus8 ();
  frame_serializer_if #(.WIDTH(1)) bus1 ();

  frame_serializer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  frame_serializer #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // seq[k] is the expected line value in frame cycle k (start .. stop).
  task automatic send8(input logic [7:0] w, input logic [0:10] seq);
    @(negedge clk);
    check("ready_before", 32'(bus8.in_ready), 1);
    bus8.in_valid = 1'b1;
    bus8.in_data  = w;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus8.in_valid = 1'b0;
        bus8.in_data  = ~w;
      end
      check($sformatf("bit%0d_%0h", k, w), 32'(bus8.tx_bit), 32'(seq[k]));
      check("frame_hi", 32'(bus8.tx_frame), 1);
      check("done", 32'(bus8.done), 32'(k == 10));
      check("ready_busy", 32'(bus8.in_ready), 0);
      check("cnt_hold", bus8.frame_cnt, exp_cnt);
    end
    exp_cnt++;
    @(negedge clk);
    check("frame_lo", 32'(bus8.tx_frame), 0);
    check("idle_line", 32'(bus8.tx_bit), 1);
    check("done_lo", 32'(bus8.done), 0);
    check("ready_after", 32'(bus8.in_ready), 1);
    check("cnt_after", bus8.frame_cnt, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bus8.in_valid = 1'b0;
    bus8.in_data  = '0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_bit", 32'(bus8.tx_bit), 1);
      check("rst_frame", 32'(bus8.tx_frame), 0);
      check("rst_done", 32'(bus8.done), 0);
      check("rst_cnt", bus8.frame_cnt, 0);
      check("rst_ready", 32'(bus8.in_ready), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_release", 32'(bus8.in_ready), 1);
    check("ready_release_w1", 32'(bus1.in_ready), 1);

    // Mid-frame reset at data bit 3 of 8'hFF
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) bus8.in_valid = 1'b0;
      check("mid_frame", 32'(bus8.tx_frame), 1);
      check("mid_done", 32'(bus8.done), 0);
    end
    check("mid_bit3", 32'(bus8.tx_bit), 1);
    rst = 1'b1;
    #1;
    check("mid_ready_rst", 32'(bus8.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_bit", 32'(bus8.tx_bit), 1);
    check("abort_frame", 32'(bus8.tx_frame), 0);
    check("abort_done", 32'(bus8.done), 0);
    check("abort_cnt", bus8.frame_cnt, 0);
    @(negedge clk);
    check("abort_done2", 32'(bus8.done), 0);
    check("abort_ready", 32'(bus8.in_ready), 1);

    // A5: 0,1,0,1,0,0,1,0,1, parity 0, stop 1
    send8(8'hA5, 11'b01010010101);
    // 07: 0,1,1,1,0,0,0,0,0, parity 1, stop 1
    send8(8'h07, 11'b01110000011);

    // Stuck valid with data changing every cycle
    base_cnt = exp_cnt;
    pos = -1;
    word = '0;
    for (int c = 0; c < 52; c++) begin
      @(negedge clk);
      if (pos < 0)       exp_bit = 1'b1;
      else if (pos == 0) exp_bit = 1'b0;
      else if (pos <= 8) exp_bit = word[pos-1];
      else if (pos == 9) exp_bit = ^word;
      else               exp_bit = 1'b1;
      check($sformatf("stuck_bit_c%0d", c), 32'(bus8.tx_bit), 32'(exp_bit));
      check("stuck_frame", 32'(bus8.tx_frame), 32'(pos >= 0));
      check("stuck_done", 32'(bus8.done), 32'(pos == 10));
      check($sformatf("stuck_ready_c%0d", c), 32'(bus8.in_ready), 32'(pos < 0));
      check("stuck_cnt", bus8.frame_cnt, exp_cnt);
      if (c == 36) check("cnt_after_36", bus8.frame_cnt, base_cnt + 32'd3);
      bus8.in_valid = (c < 40);
      d = 8'(c * 37 + 11);
      bus8.in_data = d;
      if (pos < 0) begin
        if (c < 40) begin
          word = d;
          pos  = 0;
        end
      end else if (pos == 10) begin
        pos = -1;
        exp_cnt++;
      end else begin
        pos++;
      end
    end
    check("stuck_total", bus8.frame_cnt, base_cnt + 32'd4);

    // WIDTH=1 sending 1'b1: 0,1,1,1
    seq1 = 4'b0111;
    @(negedge clk);
    check("w1_ready", 32'(bus1.in_ready), 1);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus1.in_valid = 1'b0;
        bus1.in_data  = 1'b0;
      end
      check($sformatf("w1_bit%0d", k), 32'(bus1.tx_bit), 32'(seq1[k]));
      check("w1_frame", 32'(bus1.tx_frame), 1);
      check("w1_done", 32'(bus1.done), 32'(k == 3));
    end
    @(negedge clk);
    check("w1_frame_lo", 32'(bus1.tx_frame), 0);
    check("w1_ready_after", 32'(bus1.in_ready), 1);
    check("w1_cnt", bus1.frame_cnt, 1);

    // Counter preloaded to all ones wraps on the next frame
    @(negedge clk);
    force dut8.count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut8.count;
    @(negedge clk);
    check("preload", bus8.frame_cnt, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    send8(8'hA5, 11'b01010010101);
    check("wrap_zero", bus8.frame_cnt, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
